// File: rtl/membus_arbiter.sv
// Round-robin 2:1 MemBus arbiter. An in-order tag FIFO routes read responses
// from the shared memory port back to the master that issued each read.
module membus_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_cmd_valid,
    output logic        ibus_cmd_ready,
    input  logic [31:0] ibus_cmd_payload_address,
    output logic        ibus_rsp_valid,
    input  logic        ibus_rsp_ready,
    output logic [31:0] ibus_rsp_payload_rdata,
    input  logic        dbus_cmd_valid,
    output logic        dbus_cmd_ready,
    input  logic [31:0] dbus_cmd_payload_address,
    input  logic        dbus_cmd_payload_write,
    input  logic [31:0] dbus_cmd_payload_wdata,
    input  logic [3:0]  dbus_cmd_payload_wmask,
    output logic        dbus_rsp_valid,
    input  logic        dbus_rsp_ready,
    output logic [31:0] dbus_rsp_payload_rdata,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic [31:0] mem_cmd_payload_address,
    output logic        mem_cmd_payload_write,
    output logic [31:0] mem_cmd_payload_wdata,
    output logic [3:0]  mem_cmd_payload_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_payload_rdata,
    output logic        err_unexpected_rsp
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic             lock;
    logic             lock_id;
    logic             prio;
    logic             grant;
    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             head;
    logic             sel_valid;
    logic             sel_write;
    logic             forwardable;
    logic             cmd_fire;
    logic             push;
    logic             pop;

    // Grant: a stalled command keeps its grant until memory accepts it.
    always_comb begin
        grant = prio;
        if (lock) begin
            grant = lock_id;
        end else if (ibus_cmd_valid && !dbus_cmd_valid) begin
            grant = 1'b0;
        end else if (dbus_cmd_valid && !ibus_cmd_valid) begin
            grant = 1'b1;
        end else begin
            grant = prio;
        end
    end

    // Command mux toward memory; reads stall on a full tag FIFO, writes never do.
    always_comb begin
        fifo_full  = (count == FULL_COUNT);
        fifo_empty = (count == {CW{1'b0}});
        if (grant) begin
            sel_valid               = dbus_cmd_valid;
            sel_write               = dbus_cmd_payload_write;
            mem_cmd_payload_address = dbus_cmd_payload_address;
            mem_cmd_payload_wdata   = dbus_cmd_payload_wdata;
            mem_cmd_payload_wmask   = dbus_cmd_payload_wmask;
        end else begin
            sel_valid               = ibus_cmd_valid;
            sel_write               = 1'b0;
            mem_cmd_payload_address = ibus_cmd_payload_address;
            mem_cmd_payload_wdata   = 32'h0000_0000;
            mem_cmd_payload_wmask   = 4'h0;
        end
        mem_cmd_payload_write = sel_write;
        forwardable    = sel_write || !fifo_full;
        mem_cmd_valid  = !reset && sel_valid && forwardable;
        ibus_cmd_ready = !reset && !grant && mem_cmd_ready && forwardable;
        dbus_cmd_ready = !reset && grant && mem_cmd_ready && forwardable;
        cmd_fire       = mem_cmd_valid && mem_cmd_ready;
        push           = cmd_fire && !sel_write;
    end

    // Response routing by the oldest outstanding tag.
    always_comb begin
        head                   = tags[rd_ptr];
        ibus_rsp_valid         = !reset && mem_rsp_valid && !fifo_empty && !head;
        dbus_rsp_valid         = !reset && mem_rsp_valid && !fifo_empty && head;
        ibus_rsp_payload_rdata = mem_rsp_payload_rdata;
        dbus_rsp_payload_rdata = mem_rsp_payload_rdata;
        mem_rsp_ready          = !reset && !fifo_empty &&
                                 (head ? dbus_rsp_ready : ibus_rsp_ready);
        pop                    = mem_rsp_valid && mem_rsp_ready;
    end

    // Lock and round-robin priority state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            prio    <= 1'b0;
        end else begin
            if (mem_cmd_valid && !mem_cmd_ready) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end else if (cmd_fire) begin
                lock    <= 1'b0;
            end
            if (cmd_fire) begin
                prio <= !grant;
            end
        end
    end

    // Tag FIFO and sticky unexpected-response flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags               <= {DEPTH{1'b0}};
            wr_ptr             <= {PW{1'b0}};
            rd_ptr             <= {PW{1'b0}};
            count              <= {CW{1'b0}};
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (mem_rsp_valid && fifo_empty) begin
                err_unexpected_rsp <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_membus_arbiter.sv
// Scenario bench for membus_arbiter: masters and memory are driven from tasks,
// expected grants and responses are queued at stimulus time and popped on output.
module tb_membus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_cmd_valid, ibus_cmd_ready;
    logic [31:0] ibus_cmd_payload_address;
    logic        ibus_rsp_valid, ibus_rsp_ready;
    logic [31:0] ibus_rsp_payload_rdata;
    logic        dbus_cmd_valid, dbus_cmd_ready;
    logic [31:0] dbus_cmd_payload_address;
    logic        dbus_cmd_payload_write;
    logic [31:0] dbus_cmd_payload_wdata;
    logic [3:0]  dbus_cmd_payload_wmask;
    logic        dbus_rsp_valid, dbus_rsp_ready;
    logic [31:0] dbus_rsp_payload_rdata;
    logic        mem_cmd_valid, mem_cmd_ready;
    logic [31:0] mem_cmd_payload_address;
    logic        mem_cmd_payload_write;
    logic [31:0] mem_cmd_payload_wdata;
    logic [3:0]  mem_cmd_payload_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_payload_rdata;
    logic        err_unexpected_rsp;

    typedef struct packed {
        logic        master;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    membus_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
        .ibus_cmd_payload_address(ibus_cmd_payload_address),
        .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_ready(ibus_rsp_ready),
        .ibus_rsp_payload_rdata(ibus_rsp_payload_rdata),
        .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
        .dbus_cmd_payload_address(dbus_cmd_payload_address),
        .dbus_cmd_payload_write(dbus_cmd_payload_write),
        .dbus_cmd_payload_wdata(dbus_cmd_payload_wdata),
        .dbus_cmd_payload_wmask(dbus_cmd_payload_wmask),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_ready(dbus_rsp_ready),
        .dbus_rsp_payload_rdata(dbus_rsp_payload_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_payload_address(mem_cmd_payload_address),
        .mem_cmd_payload_write(mem_cmd_payload_write),
        .mem_cmd_payload_wdata(mem_cmd_payload_wdata),
        .mem_cmd_payload_wmask(mem_cmd_payload_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_payload_rdata(mem_rsp_payload_rdata),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus_cmd_valid = 1'b0; ibus_cmd_payload_address = 32'h0;
        dbus_cmd_valid = 1'b0; dbus_cmd_payload_address = 32'h0;
        dbus_cmd_payload_write = 1'b0; dbus_cmd_payload_wdata = 32'h0;
        dbus_cmd_payload_wmask = 4'h0;
        mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_payload_rdata = 32'h0;
        ibus_rsp_ready = 1'b0; dbus_rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        ibus_cmd_valid = 1'b1; dbus_cmd_valid = 1'b1; mem_cmd_ready = 1'b1;
        mem_rsp_valid = 1'b1; ibus_rsp_ready = 1'b1; dbus_rsp_ready = 1'b1;
        tick();
        checks++; if (mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_cmd_valid got %b want 0", mem_cmd_valid); end
        checks++; if (ibus_cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ibus_cmd_ready got %b want 0", ibus_cmd_ready); end
        checks++; if (dbus_cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_dbus_cmd_ready got %b want 0", dbus_cmd_ready); end
        checks++; if (mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_rsp_ready got %b want 0", mem_rsp_ready); end
        checks++; if ({ibus_rsp_valid, dbus_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid got %b want 00", {ibus_rsp_valid, dbus_rsp_valid}); end
        idle_inputs();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_unexpected_rsp); end
    endtask

    task automatic test_single_read();
        exp_t e;
        do_reset();
        dbus_cmd_payload_write = 1'b1; dbus_cmd_payload_wdata = 32'hFFFF_FFFF;
        dbus_cmd_payload_wmask = 4'hF; dbus_cmd_payload_address = 32'h0000_0900;
        ibus_cmd_valid = 1'b1; ibus_cmd_payload_address = 32'h0000_0100;
        mem_cmd_ready = 1'b1;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        checks++; if (mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL single_cmd_valid got %b want 1", mem_cmd_valid); end
        checks++; if (mem_cmd_payload_address !== 32'h0000_0100) begin errors++; $display("FAIL single_addr got %h want 00000100", mem_cmd_payload_address); end
        checks++; if ({mem_cmd_payload_write, mem_cmd_payload_wmask} !== 5'b0) begin errors++; $display("FAIL single_write_mask got %b want 00000", {mem_cmd_payload_write, mem_cmd_payload_wmask}); end
        checks++; if (mem_cmd_payload_wdata !== 32'h0) begin errors++; $display("FAIL single_wdata got %h want 0", mem_cmd_payload_wdata); end
        checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b10) begin errors++; $display("FAIL single_cmd_ready got %b want 10", {ibus_cmd_ready, dbus_cmd_ready}); end
        tick();
        ibus_cmd_valid = 1'b0;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_payload_rdata = 32'hDEAD_BEEF;
        ibus_rsp_ready = 1'b1; dbus_rsp_ready = 1'b1;
        #1;
        e = exp_q.pop_front();
        checks++; if ({ibus_rsp_valid, dbus_rsp_valid} !== {!e.master, e.master}) begin errors++; $display("FAIL single_rsp_valid got %b want %b", {ibus_rsp_valid, dbus_rsp_valid}, {!e.master, e.master}); end
        checks++; if (ibus_rsp_payload_rdata !== e.data) begin errors++; $display("FAIL single_rdata got %h want %h", ibus_rsp_payload_rdata, e.data); end
        checks++; if (mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL single_mem_rsp_ready got %b want 1", mem_rsp_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_alternate();
        exp_t e;
        do_reset();
        ibus_cmd_valid = 1'b1; ibus_cmd_payload_address = 32'h0000_1000;
        dbus_cmd_valid = 1'b1; dbus_cmd_payload_address = 32'h0000_2000;
        mem_cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 1) exp_q.push_back({1'b1, dbus_cmd_payload_address});
            else            exp_q.push_back({1'b0, ibus_cmd_payload_address});
            #1;
            e = exp_q.pop_front();
            checks++; if (mem_cmd_payload_address !== e.data) begin errors++; $display("FAIL alt_addr[%0d] got %h want %h", k, mem_cmd_payload_address, e.data); end
            checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== {!e.master, e.master}) begin errors++; $display("FAIL alt_ready[%0d] got %b want %b", k, {ibus_cmd_ready, dbus_cmd_ready}, {!e.master, e.master}); end
            tick();
            if (e.master) dbus_cmd_payload_address = dbus_cmd_payload_address + 32'd4;
            else          ibus_cmd_payload_address = ibus_cmd_payload_address + 32'd4;
        end
        #1;
        checks++; if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready} !== 3'b000) begin errors++; $display("FAIL alt_full_stall got %b want 000", {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready}); end
        ibus_cmd_valid = 1'b0;
        dbus_cmd_payload_write = 1'b1; dbus_cmd_payload_address = 32'h0000_2100;
        dbus_cmd_payload_wdata = 32'hCAFE_F00D; dbus_cmd_payload_wmask = 4'b0011;
        #1;
        checks++; if ({mem_cmd_valid, mem_cmd_payload_write, dbus_cmd_ready} !== 3'b111) begin errors++; $display("FAIL alt_write_pass got %b want 111", {mem_cmd_valid, mem_cmd_payload_write, dbus_cmd_ready}); end
        checks++; if ({mem_cmd_payload_wdata, mem_cmd_payload_wmask} !== {32'hCAFE_F00D, 4'b0011}) begin errors++; $display("FAIL alt_write_data got %h want cafef00d3", {mem_cmd_payload_wdata, mem_cmd_payload_wmask}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        dbus_cmd_valid = 1'b1; dbus_cmd_payload_address = 32'h0000_3000;
        mem_cmd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                ibus_cmd_valid = 1'b1; ibus_cmd_payload_address = 32'h0000_4000;
            end
            #1;
            checks++; if ({mem_cmd_valid, mem_cmd_payload_address} !== {1'b1, 32'h0000_3000}) begin errors++; $display("FAIL lock_hold[%0d] got %b/%h want 1/00003000", c, mem_cmd_valid, mem_cmd_payload_address); end
            checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== 2'b00) begin errors++; $display("FAIL lock_ready[%0d] got %b want 00", c, {ibus_cmd_ready, dbus_cmd_ready}); end
            tick();
        end
        mem_cmd_ready = 1'b1;
        #1;
        checks++; if ({mem_cmd_payload_address, dbus_cmd_ready, ibus_cmd_ready} !== {32'h0000_3000, 2'b10}) begin errors++; $display("FAIL lock_accept got %h/%b%b want 00003000/10", mem_cmd_payload_address, dbus_cmd_ready, ibus_cmd_ready); end
        tick();
        dbus_cmd_payload_address = 32'h0000_3004;
        #1;
        checks++; if ({mem_cmd_payload_address, ibus_cmd_ready, dbus_cmd_ready} !== {32'h0000_4000, 2'b10}) begin errors++; $display("FAIL lock_next_ibus got %h/%b%b want 00004000/10", mem_cmd_payload_address, ibus_cmd_ready, dbus_cmd_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_order();
        exp_t e;
        logic [3:0] masters;
        logic [31:0] rsp_data [4];
        rsp_data[0] = 32'hAAAA_0001; rsp_data[1] = 32'hBBBB_0002;
        rsp_data[2] = 32'hCCCC_0003; rsp_data[3] = 32'hDDDD_0004;
        masters = 4'b0110;
        do_reset();
        mem_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ibus_cmd_valid = !masters[i]; ibus_cmd_payload_address = 32'h0000_5000 + 32'(i);
            dbus_cmd_valid = masters[i];  dbus_cmd_payload_address = 32'h0000_6000 + 32'(i);
            exp_q.push_back({masters[i], rsp_data[i]});
            #1;
            checks++; if ({ibus_cmd_ready, dbus_cmd_ready} !== {!masters[i], masters[i]}) begin errors++; $display("FAIL order_issue[%0d] got %b want %b", i, {ibus_cmd_ready, dbus_cmd_ready}, {!masters[i], masters[i]}); end
            tick();
        end
        idle_inputs();
        ibus_rsp_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++) begin
            e = exp_q[0];
            mem_rsp_payload_rdata = e.data;
            dbus_rsp_ready = (cyc >= 3);
            #1;
            checks++; if ({ibus_rsp_valid, dbus_rsp_valid} !== {!e.master, e.master}) begin errors++; $display("FAIL order_route[%0d] got %b want %b", cyc, {ibus_rsp_valid, dbus_rsp_valid}, {!e.master, e.master}); end
            checks++; if ((e.master ? dbus_rsp_payload_rdata : ibus_rsp_payload_rdata) !== e.data) begin errors++; $display("FAIL order_rdata[%0d] got %h want %h", cyc, e.master ? dbus_rsp_payload_rdata : ibus_rsp_payload_rdata, e.data); end
            checks++; if (mem_rsp_ready !== (e.master ? dbus_rsp_ready : ibus_rsp_ready)) begin errors++; $display("FAIL order_mem_rsp_ready[%0d] got %b want %b", cyc, mem_rsp_ready, e.master ? dbus_rsp_ready : ibus_rsp_ready); end
            if (e.master ? dbus_rsp_ready : ibus_rsp_ready) void'(exp_q.pop_front());
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_unexpected();
        do_reset();
        mem_rsp_valid = 1'b1; ibus_rsp_ready = 1'b1; dbus_rsp_ready = 1'b1;
        #1;
        checks++; if ({mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid} !== 3'b000) begin errors++; $display("FAIL unexp_ack got %b want 000", {mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid}); end
        tick();
        checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL unexp_err_set got %b want 1", err_unexpected_rsp); end
        mem_rsp_valid = 1'b0;
        tick();
        tick();
        checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL unexp_err_sticky got %b want 1", err_unexpected_rsp); end
        idle_inputs();
    endtask

    task automatic test_reset_outstanding();
        do_reset();
        mem_cmd_ready = 1'b1;
        ibus_cmd_valid = 1'b1; ibus_cmd_payload_address = 32'h0000_0010;
        tick();
        ibus_cmd_valid = 1'b0; dbus_cmd_valid = 1'b1; dbus_cmd_payload_address = 32'h0000_0020;
        tick();
        dbus_cmd_valid = 1'b0; ibus_cmd_valid = 1'b1; ibus_cmd_payload_address = 32'h0000_0030;
        tick();
        mem_cmd_ready = 1'b0;
        dbus_cmd_valid = 1'b1; dbus_cmd_payload_address = 32'h0000_0040;
        ibus_cmd_payload_address = 32'h0000_0050;
        #1;
        checks++; if (mem_cmd_payload_address !== 32'h0000_0040) begin errors++; $display("FAIL rsto_pre_grant got %h want 00000040", mem_cmd_payload_address); end
        tick();
        reset = 1'b1;
        mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b1;
        ibus_rsp_ready = 1'b1; dbus_rsp_ready = 1'b1;
        #1;
        checks++; if ({mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid} !== 6'b0) begin errors++; $display("FAIL rsto_outputs got %b want 000000", {mem_cmd_valid, ibus_cmd_ready, dbus_cmd_ready, mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid}); end
        tick();
        mem_rsp_valid = 1'b0; mem_cmd_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (mem_cmd_payload_address !== 32'h0000_0050) begin errors++; $display("FAIL rsto_lock_prio_cleared got %h want 00000050", mem_cmd_payload_address); end
        mem_rsp_valid = 1'b1;
        #1;
        checks++; if ({mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid} !== 3'b000) begin errors++; $display("FAIL rsto_tags_dropped got %b want 000", {mem_rsp_ready, ibus_rsp_valid, dbus_rsp_valid}); end
        tick();
        checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL rsto_err got %b want 1", err_unexpected_rsp); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_order();
        test_unexpected();
        test_reset_outstanding();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
